// File: rtl/dmem_ctrl.sv
// Data-memory controller: round-robin arbitration between a CPU load/store port (A)
// and a word-only loader/debug port (B) onto one byte-lane memory with registered read.
//   IDLE   | waiting for a request; ready driven for the granted port
//   ACCESS | address (and write strobe for stores) presented to memory
//   DATA   | read word returned by memory, formatted and registered
//   RESP   | one-cycle valid on the owning port
module dmem_ctrl #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  a_req_i,
    input  logic                  a_we_i,
    input  logic [2:0]            a_funct3_i,
    input  logic [31:0]           a_addr_i,
    input  logic [31:0]           a_wdata_i,
    output logic                  a_ready_o,
    output logic                  a_valid_o,
    output logic [31:0]           a_rdata_o,
    output logic                  a_err_o,
    input  logic                  b_req_i,
    input  logic                  b_we_i,
    input  logic [31:0]           b_addr_i,
    input  logic [31:0]           b_wdata_i,
    output logic                  b_ready_o,
    output logic                  b_valid_o,
    output logic [31:0]           b_rdata_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_wmask_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i
);
    typedef enum logic [1:0] {IDLE, ACCESS, DATA, RESP} state_t;

    state_t                state_q;
    logic                  port_q;
    logic                  we_q;
    logic                  last_q;
    logic [2:0]            funct3_q;
    logic [1:0]            off_q;
    logic                  a_valid_q, a_err_q, b_valid_q;
    logic [31:0]           a_rdata_q, b_rdata_q;
    logic                  mem_we_q;
    logic [3:0]            mem_wmask_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_wdata_q;

    logic        grant_a, grant_b, acc_a, acc_b, a_illegal;
    logic [3:0]  st_mask;
    logic [31:0] st_data, shifted, ld_data, sel_addr;
    logic        unused_addr_bits;

    // last_q = 1 means B was granted last, so A wins a tie out of reset
    assign grant_a   = a_req_i && (!b_req_i || last_q);
    assign grant_b   = b_req_i && !grant_a;
    assign a_ready_o = rst_n_i && (state_q == IDLE) && grant_a;
    assign b_ready_o = rst_n_i && (state_q == IDLE) && grant_b;
    assign acc_a     = a_req_i && a_ready_o;
    assign acc_b     = b_req_i && b_ready_o;
    assign sel_addr  = acc_b ? b_addr_i : a_addr_i;

    assign unused_addr_bits = ^{a_addr_i[31:ADDR_WIDTH+2], b_addr_i[31:ADDR_WIDTH+2], b_addr_i[1:0]};

    always_comb begin
        if (a_we_i) a_illegal = !(a_funct3_i inside {3'b000, 3'b001, 3'b010});
        else        a_illegal = !(a_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        if (a_funct3_i[1:0] == 2'b01 && a_addr_i[0])          a_illegal = 1'b1;
        if (a_funct3_i[1:0] == 2'b10 && a_addr_i[1:0] != 2'b00) a_illegal = 1'b1;
    end

    always_comb begin
        st_mask = 4'b1111;
        st_data = a_wdata_i;
        case (a_funct3_i[1:0])
            2'b00: begin
                st_mask = 4'b0001 << a_addr_i[1:0];
                st_data = {4{a_wdata_i[7:0]}};
            end
            2'b01: begin
                st_mask = a_addr_i[1] ? 4'b1100 : 4'b0011;
                st_data = {2{a_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted = mem_rdata_i >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  ld_data = {24'h0, shifted[7:0]};
            3'b101:  ld_data = {16'h0, shifted[15:0]};
            default: ld_data = mem_rdata_i;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            port_q      <= 1'b0;
            we_q        <= 1'b0;
            last_q      <= 1'b1;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            a_valid_q   <= 1'b0;
            a_err_q     <= 1'b0;
            b_valid_q   <= 1'b0;
            a_rdata_q   <= 32'h0;
            b_rdata_q   <= 32'h0;
            mem_we_q    <= 1'b0;
            mem_wmask_q <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0;
        end else begin
            a_valid_q   <= 1'b0;
            a_err_q     <= 1'b0;
            b_valid_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wmask_q <= 4'b0000;
            case (state_q)
                IDLE: begin
                    if (acc_a || acc_b) begin
                        port_q      <= acc_b;
                        last_q      <= acc_b;
                        we_q        <= acc_b ? b_we_i : a_we_i;
                        funct3_q    <= acc_b ? 3'b010 : a_funct3_i;
                        off_q       <= acc_b ? 2'b00 : a_addr_i[1:0];
                        mem_addr_q  <= sel_addr[ADDR_WIDTH+1:2];
                        mem_wdata_q <= acc_b ? b_wdata_i : st_data;
                        if (acc_a && a_illegal) begin
                            state_q   <= RESP;
                            a_valid_q <= 1'b1;
                            a_err_q   <= 1'b1;
                        end else begin
                            state_q <= ACCESS;
                            if (acc_b ? b_we_i : a_we_i) begin
                                mem_we_q    <= 1'b1;
                                mem_wmask_q <= acc_b ? 4'b1111 : st_mask;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (we_q) begin
                        state_q   <= RESP;
                        a_valid_q <= !port_q;
                        b_valid_q <= port_q;
                    end else begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    state_q   <= RESP;
                    a_valid_q <= !port_q;
                    b_valid_q <= port_q;
                    if (port_q) b_rdata_q <= mem_rdata_i;
                    else        a_rdata_q <= ld_data;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_valid_o   = a_valid_q;
    assign a_err_o     = a_err_q;
    assign a_rdata_o   = a_rdata_q;
    assign b_valid_o   = b_valid_q;
    assign b_rdata_o   = b_rdata_q;
    assign mem_we_o    = mem_we_q;
    assign mem_wmask_o = mem_wmask_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: transaction-level reference model checked every cycle,
// plus directed load/store/arbitration/reset scenarios with literal expectations.
module tb_dmem_ctrl;
    localparam int AW = 12;

    logic          clk, rst_n;
    logic          a_req, a_we, b_req, b_we;
    logic [2:0]    a_funct3;
    logic [31:0]   a_addr, a_wdata, b_addr, b_wdata;
    logic          a_ready, a_valid, a_err, b_ready, b_valid;
    logic [31:0]   a_rdata, b_rdata;
    logic          mem_we;
    logic [3:0]    mem_wmask;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    dmem_ctrl #(.ADDR_WIDTH(AW)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .a_req_i(a_req), .a_we_i(a_we), .a_funct3_i(a_funct3), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_ready_o(a_ready), .a_valid_o(a_valid), .a_rdata_o(a_rdata), .a_err_o(a_err),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_ready_o(b_ready), .b_valid_o(b_valid), .b_rdata_o(b_rdata),
        .mem_we_o(mem_we), .mem_wmask_o(mem_wmask), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Attached memory with registered read address
    logic [31:0] tmem [0:(1<<AW)-1] = '{default: 32'h0};
    logic [31:0] rd_q = 32'h0;
    assign mem_rdata = rd_q;
    always @(posedge clk) begin
        for (int l = 0; l < 4; l++)
            if (mem_we && mem_wmask[l]) tmem[mem_addr][8*l +: 8] <= mem_wdata[8*l +: 8];
        rd_q <= tmem[mem_addr];
    end

    int n_vec = 0, n_fail = 0, cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: one outstanding transaction described by its size, lanes and response cycle
    logic [31:0] mmem [0:(1<<AW)-1] = '{default: 32'h0};
    bit          m_busy = 0, m_last = 1, m_port = 0, m_we = 0, m_err = 0;
    bit          exp_acc_a = 0, exp_acc_b = 0;
    logic [2:0]  m_f3 = 3'd0;
    logic [31:0] m_addr = 0, m_bus_wd = 0, m_rdA = 0, m_rdB = 0;
    logic [3:0]  m_mask = 0;
    int          m_acc = -10, m_r = -10, m_sz = 4, m_off = 0;

    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'd1 || f3 == 3'd5) return 2;
        if (f3 == 3'd2) return 4;
        return 1;
    endfunction

    always @(posedge clk) begin
        logic [31:0] w, v, wd;
        cyc = cyc + 1;
        if (!rst_n) begin
            m_busy = 0; m_last = 1; m_rdA = 0; m_rdB = 0;
        end else begin
            if (m_busy && m_we && !m_err && cyc == m_acc + 1)
                for (int l = 0; l < 4; l++)
                    if (m_mask[l]) mmem[m_addr[AW+1:2]][8*l +: 8] = m_bus_wd[8*l +: 8];
            if (m_busy && !m_we && !m_err && cyc == m_r) begin
                w = mmem[m_addr[AW+1:2]];
                if (m_port) m_rdB = w;
                else begin
                    v = w >> (8 * m_off);
                    if (m_sz == 1) v = (m_f3 == 3'd0 && v[7])  ? (v | 32'hFFFFFF00) : (v & 32'hFF);
                    if (m_sz == 2) v = (m_f3 == 3'd1 && v[15]) ? (v | 32'hFFFF0000) : (v & 32'hFFFF);
                    m_rdA = v;
                end
            end
            if (exp_acc_a || exp_acc_b) begin
                m_busy = 1;
                m_port = exp_acc_b;
                m_last = exp_acc_b;
                m_we   = m_port ? b_we : a_we;
                m_f3   = m_port ? 3'd2 : a_funct3;
                m_addr = m_port ? {b_addr[31:2], 2'b00} : a_addr;
                wd     = m_port ? b_wdata : a_wdata;
                m_sz   = size_of(m_f3);
                m_off  = int'(m_addr[1:0]);
                m_err  = !m_port && ((m_we ? (m_f3 > 3'd2) : !(m_f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}))
                                     || (m_off % m_sz != 0));
                m_mask = m_we ? 4'(((1 << m_sz) - 1) << m_off) : 4'b0;
                for (int l = 0; l < 4; l++) m_bus_wd[8*l +: 8] = wd[8*(l % m_sz) +: 8];
                m_acc  = cyc;
                m_r    = cyc - 1 + (m_err ? 1 : (m_we ? 2 : 3));
            end
        end
    end

    always @(negedge clk) begin
        bit idle, ga, gb, resp, in_acc, wexp;
        if (!rst_n) begin
            chk("rst_a_ready", a_ready, 0);   chk("rst_b_ready", b_ready, 0);
            chk("rst_a_valid", a_valid, 0);   chk("rst_b_valid", b_valid, 0);
            chk("rst_a_err", a_err, 0);       chk("rst_mem_we", mem_we, 0);
            chk("rst_a_rdata", a_rdata, 0);   chk("rst_b_rdata", b_rdata, 0);
            chk("rst_mem_wmask", mem_wmask, 0); chk("rst_mem_addr", 32'(mem_addr), 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            exp_acc_a = 0; exp_acc_b = 0;
        end else begin
            idle = !m_busy || cyc > m_r;
            ga   = idle && a_req && (!b_req || m_last);
            gb   = idle && b_req && !(a_req && (!b_req || m_last));
            chk("a_ready", a_ready, ga);
            chk("b_ready", b_ready, gb);
            resp = m_busy && cyc == m_r;
            chk("a_valid", a_valid, resp && !m_port);
            chk("b_valid", b_valid, resp && m_port);
            chk("a_err", a_err, resp && !m_port && m_err);
            chk("a_rdata", a_rdata, m_rdA);
            chk("b_rdata", b_rdata, m_rdB);
            in_acc = m_busy && cyc == m_acc && !m_err;
            wexp   = in_acc && m_we;
            chk("mem_we", mem_we, wexp);
            chk("mem_wmask", mem_wmask, wexp ? m_mask : 4'b0);
            if (in_acc) chk("mem_addr", 32'(mem_addr), 32'(m_addr[AW+1:2]));
            if (wexp)   chk("mem_wdata", mem_wdata, m_bus_wd);
            exp_acc_a = ga; exp_acc_b = gb;
        end
    end

    task automatic a_txn(input logic we, input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] wd,
                         input int exp_lat, input logic [3:0] exp_mask, input logic exp_er,
                         input logic chk_rd, input logic [31:0] exp_rd);
        int acc = 0;
        bit got = 0;
        logic [3:0] seen = 4'b0;
        @(posedge clk); #1;
        a_req = 1; a_we = we; a_funct3 = f3; a_addr = ad; a_wdata = wd;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (a_ready) begin got = 1; acc = cyc; end
        end
        if (!got) begin chk("a_accept_timeout", 0, 1); a_req = 0; return; end
        @(posedge clk); #1; a_req = 0;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (mem_we) seen = mem_wmask;
            if (a_valid) got = 1;
        end
        if (!got) begin chk("a_valid_timeout", 0, 1); return; end
        chk("lit_latency", cyc - acc, exp_lat);
        chk("lit_wmask", seen, exp_mask);
        chk("lit_err", a_err, exp_er);
        if (chk_rd) chk("lit_rdata", a_rdata, exp_rd);
    endtask

    logic        ta_we [4] = '{1, 0, 1, 0};
    logic [2:0]  ta_f3 [4] = '{3'd2, 3'd2, 3'd0, 3'd2};
    logic [31:0] ta_ad [4] = '{32'h300, 32'h300, 32'h301, 32'h300};
    logic [31:0] ta_wd [4] = '{32'h01020304, 0, 32'hAB, 0};
    logic        tb_we [4] = '{1, 0, 1, 0};
    logic [31:0] tb_ad [4] = '{32'h103, 32'h100, 32'h10C, 32'h10C};
    logic [31:0] tb_wd [4] = '{32'h11223344, 0, 32'hA5A5A5A5, 0};

    initial begin
        bit ga, gb, got;
        int ai, bi, ngr, nvalid;
        bit order [6];
        a_req = 0; a_we = 0; a_funct3 = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
        rst_n = 1;
        #2 rst_n = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;

        // Both ports requesting continuously: grants must alternate starting with A
        ai = 0; bi = 0; ngr = 0;
        a_we = ta_we[0]; a_funct3 = ta_f3[0]; a_addr = ta_ad[0]; a_wdata = ta_wd[0];
        b_we = tb_we[0]; b_addr = tb_ad[0]; b_wdata = tb_wd[0];
        a_req = 1; b_req = 1;
        for (int i = 0; i < 80 && ngr < 6; i++) begin
            @(negedge clk);
            ga = a_ready; gb = b_ready;
            @(posedge clk); #1;
            if (ga) begin
                order[ngr] = 0; ngr++; ai++;
                a_we = ta_we[ai]; a_funct3 = ta_f3[ai]; a_addr = ta_ad[ai]; a_wdata = ta_wd[ai];
            end
            if (gb) begin
                order[ngr] = 1; ngr++; bi++;
                b_we = tb_we[bi]; b_addr = tb_ad[bi]; b_wdata = tb_wd[bi];
            end
        end
        a_req = 0; b_req = 0;
        chk("rr_grant_count", ngr, 6);
        for (int i = 0; i < 6; i++) chk("rr_order", 32'(order[i]), 32'(i % 2));
        repeat (4) @(posedge clk);
        chk("b_write_word40", tmem[12'h040], 32'h11223344);
        chk("b_read_raw", b_rdata, 32'h11223344);

        // Word, byte and halfword accesses
        a_txn(1, 3'd2, 32'h104, 32'hDEADBEEF, 2, 4'b1111, 0, 0, 0);
        a_txn(0, 3'd2, 32'h104, 0, 3, 4'b0000, 0, 1, 32'hDEADBEEF);
        a_txn(1, 3'd0, 32'h107, 32'h80, 2, 4'b1000, 0, 0, 0);
        a_txn(0, 3'd0, 32'h107, 0, 3, 4'b0000, 0, 1, 32'hFFFFFF80);
        a_txn(0, 3'd4, 32'h107, 0, 3, 4'b0000, 0, 1, 32'h00000080);
        a_txn(1, 3'd1, 32'h106, 32'h1234, 2, 4'b1100, 0, 0, 0);
        a_txn(0, 3'd1, 32'h106, 0, 3, 4'b0000, 0, 1, 32'h00001234);
        a_txn(0, 3'd1, 32'h104, 0, 3, 4'b0000, 0, 1, 32'hFFFFBEEF);
        a_txn(0, 3'd5, 32'h104, 0, 3, 4'b0000, 0, 1, 32'h0000BEEF);

        // Illegal requests: error after one cycle, nothing written, rdata untouched
        a_txn(0, 3'd2, 32'h102, 0, 1, 4'b0000, 1, 1, 32'h0000BEEF);
        a_txn(1, 3'd1, 32'h101, 32'hFFFF, 1, 4'b0000, 1, 1, 32'h0000BEEF);
        a_txn(0, 3'd3, 32'h104, 0, 1, 4'b0000, 1, 1, 32'h0000BEEF);
        a_txn(1, 3'd4, 32'h104, 32'h0, 1, 4'b0000, 1, 1, 32'h0000BEEF);
        a_txn(0, 3'd2, 32'h104, 0, 3, 4'b0000, 0, 1, 32'h1234BEEF);

        // Aliasing: high address bits ignored
        a_txn(0, 3'd2, 32'h8000_4104, 0, 3, 4'b0000, 0, 1, 32'h1234BEEF);

        // Reset during the ACCESS cycle of a store discards it
        a_txn(1, 3'd2, 32'h200, 32'hCAFEF00D, 2, 4'b1111, 0, 0, 0);
        @(posedge clk); #1;
        a_req = 1; a_we = 1; a_funct3 = 3'd2; a_addr = 32'h200; a_wdata = 32'h55555555;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (a_ready) got = 1;
        end
        chk("rst_test_accept", got, 1);
        @(posedge clk); #1;
        a_req = 0; rst_n = 0;
        @(negedge clk);
        chk("rst_async_mem_we", mem_we, 0);
        @(posedge clk); #1 rst_n = 1;
        nvalid = 0;
        repeat (5) begin
            @(negedge clk);
            if (a_valid) nvalid++;
        end
        chk("rst_no_valid", nvalid, 0);
        chk("rst_mem_kept", tmem[12'h080], 32'hCAFEF00D);
        a_txn(0, 3'd2, 32'h200, 0, 3, 4'b0000, 0, 1, 32'hCAFEF00D);

        repeat (3) @(posedge clk);
        got = 1;
        for (int i = 0; i < (1 << AW); i++) if (tmem[i] !== mmem[i]) got = 0;
        chk("memory_image", got, 1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 12: word-address width of the attached byte-lane data memory (2**ADDR_WIDTH words).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 a_req  input  1  CPU port request; a_we input 1 (1=store); a_funct3 input 3 (RV32I load/store funct3); a_addr input 32 (byte address); a_wdata input 32.
REQ-005 a_ready  output  1  CPU request accepted this cycle; a_valid output 1 one-cycle response strobe; a_rdata output 32 formatted load data; a_err output 1 misaligned/illegal flag, qualified by a_valid.
REQ-006 b_req  input  1  loader/debug port request; b_we input 1; b_addr input 32 (byte address, addr[1:0] ignored); b_wdata input 32.
REQ-007 b_ready  output  1  and b_valid output 1, b_rdata output 32: same meaning as port A; port B has no error output.
REQ-008 mem_we  output  1;  mem_wmask output 4;  mem_addr output ADDR_WIDTH;  mem_wdata output 32: memory write/address side.
REQ-009 mem_rdata  input  32  memory read data, valid one cycle after mem_addr is presented (registered read address).

Function
REQ-010 FSM states IDLE, ACCESS, DATA, RESP; at most one transaction outstanding.
REQ-011 IDLE: a_ready/b_ready asserted combinationally for the granted requester only; accept = req && ready.
REQ-012 Arbitration round-robin: both requesting -> grant the port not granted last; single requester -> granted; after reset, A has priority.
REQ-013 On accept, register port id, we, funct3, address, wdata; next state ACCESS, or RESP with error if the A request is illegal (REQ-017).
REQ-014 mem_addr = registered byte address bits [ADDR_WIDTH+1:2]; higher bits ignored (aliasing, no error).
REQ-015 ACCESS: mem_we=1 for stores; loads mem_we=0; next state RESP for stores, DATA for loads. mem_we=0 and mem_wmask=0 in every state except ACCESS.
REQ-016 Store lanes (port A): SB mask = 1<<addr[1:0], byte replicated to all 4 lanes; SH mask = addr[1]?1100:0011, halfword replicated to both halves; SW mask 1111. Port B: mask 1111, wdata unchanged.
REQ-017 Port A error: funct3 not in {000,001,010,100,101} for loads or {000,001,010} for stores; halfword with addr[0]=1; word with addr[1:0]!=0. Error -> no memory access, mem_we stays 0.
REQ-018 DATA: capture mem_rdata; port A shifts right by 8*addr[1:0], then LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged; port B raw word. Result registered into the owning port's rdata; next RESP.
REQ-019 RESP: owning port's valid=1 for exactly one cycle (a_err=1 if errored, else 0); next IDLE. Latency from accept edge: store valid 2 cycles later, load 3, error 1.
REQ-020 a_rdata/b_rdata hold their last value until the next load response on that port; stores and errors do not modify rdata.
REQ-021 Requests asserted while not in IDLE are not accepted (ready=0); requester holds them; no request queueing.
REQ-022 Simultaneous response and new request: the new request is accepted only in the following IDLE cycle.

Reset
REQ-023 rst_n low asynchronously forces: state IDLE, all ready/valid/err 0, a_rdata=b_rdata=0, mem_we=0, mem_wmask=0, mem_addr=0, mem_wdata=0, last-grant pointer=B.
REQ-024 Reset during an outstanding transaction discards it; no response is issued; a store in ACCESS whose edge occurs while rst_n low is not written.

Verification
REQ-025 A: SW 0x0000_0104 data 0xDEADBEEF, then LW 0x104 -> store valid 2 cycles after accept, mem_wmask=1111; load a_rdata=0xDEADBEEF, a_err=0, 3-cycle latency.
REQ-026 A: SB 0x107 data 0x80, then LB 0x107 and LBU 0x107 -> mem_wmask=1000; LB a_rdata=0xFFFFFF80, LBU 0x00000080; SH 0x106 0x1234 -> mask 1100, LH 0x106 = 0x00001234.
REQ-027 A: LW 0x102, SH 0x101, funct3=011 -> a_err=1 one cycle after accept, mem_we never asserted, memory unchanged, a_rdata unchanged.
REQ-028 a_req and b_req held high continuously, mixed ops -> grants alternate A,B,A,B starting with A after reset; no port starved; B write 0x0000_0103 data 0x11223344 lands at word 0x40, mask 1111.
REQ-029 rst_n pulsed low during ACCESS of SW 0x200 -> outputs reset immediately, no a_valid, subsequent LW 0x200 returns prior contents.
